// File: rtl/q_digit_collector_pkg.sv
// ============================================================================
// Module  : q_digit_collector_pkg
// Brief   : Digit encodings, state type and default sizing shared with V-logic.
// Revision: 1.0
// ============================================================================
`default_nettype none

package q_digit_collector_pkg;

   localparam int DEF_UNROLLING    = 64;
   localparam int DEF_ONLINE_DELAY = 3;
   localparam int DEF_CNT_WIDTH    = 7;

   localparam logic [1:0] DIGIT_POS  = 2'b10;
   localparam logic [1:0] DIGIT_NEG  = 2'b01;
   localparam logic [1:0] DIGIT_ZERO = 2'b00;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WARMUP = 2'd1,
      ST_ACCUM  = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/q_digit_collector_otf_converter.sv
// ============================================================================
// Module  : otf_converter
// Brief   : On-the-fly signed-digit to two's-complement conversion (Q/QM pair).
// Revision: 1.0
// ============================================================================
`default_nettype none

module otf_converter #(
   parameter int WIDTH = 65
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear_i,
   input  logic             beat_i,
   input  logic             pos_i,
   input  logic             neg_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] qm_q;

   // QM always holds Q - ulp, so a -1 digit only needs to borrow from QM.
   always_ff @(posedge clk) begin
      if (!rst_n || clear_i) begin
         q_q  <= '0;
         qm_q <= '1;
      end else if (beat_i) begin
         if (pos_i) begin
            q_q  <= {q_q[WIDTH-2:0], 1'b1};
            qm_q <= {q_q[WIDTH-2:0], 1'b0};
         end else if (neg_i) begin
            q_q  <= {qm_q[WIDTH-2:0], 1'b1};
            qm_q <= {qm_q[WIDTH-2:0], 1'b0};
         end else begin
            q_q  <= {q_q[WIDTH-2:0], 1'b0};
            qm_q <= {qm_q[WIDTH-2:0], 1'b1};
         end
      end
   end

   assign q_o = q_q;

endmodule

`default_nettype wire

// File: rtl/q_digit_collector.sv
// ============================================================================
// Module  : q_digit_collector
// Brief   : Collects online-divider quotient digits into redundant vectors and
//           produces the two's-complement quotient. Macro OTF_CONV_EN selects
//           on-the-fly conversion instead of a final vector subtraction.
// Revision: 1.0
// ============================================================================
`default_nettype none

module q_digit_collector
   import q_digit_collector_pkg::*;
#(
   parameter int UNROLLING    = DEF_UNROLLING,
   parameter int ONLINE_DELAY = DEF_ONLINE_DELAY,
   parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic                 q_valid_i,
   input  logic [1:0]           q_value_i,
   output logic [UNROLLING-1:0] q_plus_vec_o,
   output logic [UNROLLING-1:0] q_minus_vec_o,
   output logic [CNT_WIDTH-1:0] digit_idx_o,
   output logic                 busy_o,
   output logic                 res_valid_o,
   input  logic                 res_ready_i,
   output logic [UNROLLING:0]   q_bin_o,
   output logic                 digit_err_o
);

   localparam logic [CNT_WIDTH-1:0] WARM_LAST =
      CNT_WIDTH'((ONLINE_DELAY == 0) ? 0 : ONLINE_DELAY - 1);
   localparam logic [CNT_WIDTH-1:0] ACC_LAST  = CNT_WIDTH'(UNROLLING + ONLINE_DELAY - 1);
   localparam logic [CNT_WIDTH-1:0] IDX_SAT   = CNT_WIDTH'(UNROLLING + ONLINE_DELAY);
   localparam logic [CNT_WIDTH-1:0] OD_C      = CNT_WIDTH'(ONLINE_DELAY);
   localparam logic [CNT_WIDTH-1:0] TOP_C     = CNT_WIDTH'(UNROLLING - 1);
   localparam state_t               FIRST_ST  = (ONLINE_DELAY == 0) ? ST_ACCUM : ST_WARMUP;

   state_t               state_q;
   logic [UNROLLING-1:0] q_plus_q,  q_plus_d;
   logic [UNROLLING-1:0] q_minus_q, q_minus_d;
   logic [CNT_WIDTH-1:0] digit_idx_q;
   logic                 busy_q;
   logic                 res_valid_q;
   logic                 digit_err_q;

   logic                 is_pos, is_neg, is_ill;
   logic                 accum_beat;
   logic                 start_clr;
   logic [CNT_WIDTH-1:0] bit_pos;
   logic [UNROLLING-1:0] bit_mask;

   assign is_pos     = (q_value_i == DIGIT_POS);
   assign is_neg     = (q_value_i == DIGIT_NEG);
   assign is_ill     = (q_value_i == 2'b11);
   assign accum_beat = (state_q == ST_ACCUM) && q_valid_i;
   assign start_clr  = (state_q == ST_IDLE) && start_i;

   // k = digit_idx - ONLINE_DELAY; first digit lands in the MSB.
   assign bit_pos  = TOP_C - (digit_idx_q - OD_C);
   assign bit_mask = UNROLLING'(1) << bit_pos;

   always_comb begin
      q_plus_d  = q_plus_q;
      q_minus_d = q_minus_q;
      if (is_pos) q_plus_d  = q_plus_q  | bit_mask;
      if (is_neg) q_minus_d = q_minus_q | bit_mask;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         q_plus_q    <= '0;
         q_minus_q   <= '0;
         digit_idx_q <= '0;
         busy_q      <= 1'b0;
         res_valid_q <= 1'b0;
         digit_err_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  q_plus_q    <= '0;
                  q_minus_q   <= '0;
                  digit_idx_q <= '0;
                  digit_err_q <= 1'b0;
                  busy_q      <= 1'b1;
                  state_q     <= FIRST_ST;
               end
            end
            ST_WARMUP: begin
               if (q_valid_i) begin
                  digit_idx_q <= digit_idx_q + 1'b1;
                  if (digit_idx_q == WARM_LAST) state_q <= ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               if (q_valid_i) begin
                  q_plus_q  <= q_plus_d;
                  q_minus_q <= q_minus_d;
                  if (is_ill) digit_err_q <= 1'b1;
                  if (digit_idx_q == ACC_LAST) begin
                     digit_idx_q <= IDX_SAT;
                     busy_q      <= 1'b0;
                     res_valid_q <= 1'b1;
                     state_q     <= ST_HOLD;
                  end else begin
                     digit_idx_q <= digit_idx_q + 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               if (res_valid_q && res_ready_i) begin
                  res_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

`ifdef OTF_CONV_EN
   logic [UNROLLING:0] otf_q;

   otf_converter #(
      .WIDTH (UNROLLING + 1)
   ) u_otf (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (start_clr),
      .beat_i  (accum_beat),
      .pos_i   (is_pos),
      .neg_i   (is_neg),
      .q_o     (otf_q)
   );

   assign q_bin_o = (state_q == ST_HOLD) ? otf_q : '0;
`else
   logic unused_otf;
   assign unused_otf = start_clr ^ accum_beat;

   assign q_bin_o = (state_q == ST_HOLD)
                  ? ({1'b0, q_plus_q} - {1'b0, q_minus_q}) : '0;
`endif

   assign q_plus_vec_o  = q_plus_q;
   assign q_minus_vec_o = q_minus_q;
   assign digit_idx_o   = digit_idx_q;
   assign busy_o        = busy_q;
   assign res_valid_o   = res_valid_q;
   assign digit_err_o   = digit_err_q;

endmodule

`default_nettype wire
